// File: rtl/cpu_defs.sv
// Shared MIPS core definitions: fetch sequencer states and
// the reset/exception vectors seen by CP0, fetch and the bench.
package cpu_defs;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_e;

    localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] CPU_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] CPU_PC_LO    = 32'h0000_3000;
    localparam logic [31:0] CPU_PC_HI    = 32'h0000_6ffc;

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register: synchronous active-low reset to the boot
// vector, loads only when enabled.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_o <= RESET_PC;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage PC sequencer: next-PC arbitration between exceptions,
// eret, stalls, a pending redirect latch and sequential fetch.
module pc_seq
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC,
    parameter logic [31:0] EXC_PC   = CPU_EXC_PC,
    parameter logic [31:0] PC_LO    = CPU_PC_LO,
    parameter logic [31:0] PC_HI    = CPU_PC_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        fetch_adel,
    output logic [31:0] fetch_cnt
);

    pc_state_e   state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_d;
    logic        pc_en;
    logic        booting;

    assign booting = (state_q == ST_BOOT);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (pc_en),
        .d_i    (pc_d),
        .q_o    (pc)
    );

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pc_d          = pc + 32'd4;
        pc_en         = 1'b0;
        if (exc_req) begin
            pc_d         = EXC_PC;
            pc_en        = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = ST_RUN;
        end else if (eret_req) begin
            pc_d         = epc;
            pc_en        = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = ST_RUN;
        end else if (booting) begin
            state_d = ST_RUN;
        end else if (stall) begin
            state_d = ST_HOLD;
            // Redirect arriving during a stall is parked; last one wins.
            if (redir_valid) begin
                pend_valid_d  = 1'b1;
                pend_target_d = redir_target;
            end
        end else if (pend_valid_q) begin
            state_d      = ST_RUN;
            pc_d         = pend_target_q;
            pc_en        = 1'b1;
            pend_valid_d = 1'b0;
        end else if (redir_valid) begin
            state_d = ST_RUN;
            pc_d    = redir_target;
            pc_en   = 1'b1;
        end else begin
            state_d = ST_RUN;
            pc_en   = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pc_valid && !stall && !exc_req && !eret_req) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            cnt_q         <= cnt_d;
        end
    end

    assign pc_valid   = !booting;
    assign fetch_cnt  = cnt_q;
    assign fetch_adel = !booting &&
                        ((pc[1:0] != 2'b00) || (pc < PC_LO) || (pc > PC_HI));

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq with an in-bench reference model and
// literal spot checks.
module tb_pc_seq;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        fetch_adel;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_fail = 0;

    pc_seq dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .fetch_adel   (fetch_adel),
        .fetch_cnt    (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what fetch must look like after each edge.
    logic [31:0] m_pc = CPU_RESET_PC;
    bit          m_boot = 1'b1;
    bit          m_pend = 1'b0;
    logic [31:0] m_ptgt = '0;
    logic [31:0] m_cnt = '0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (!reset) begin
            m_pc = CPU_RESET_PC;
            m_boot = 1'b1;
            m_pend = 1'b0;
            m_cnt = 0;
        end else begin
            if (!m_boot && !stall && !exc_req && !eret_req) m_cnt = m_cnt + 1;
            if (exc_req) begin
                m_pc = CPU_EXC_PC; m_boot = 0; m_pend = 0;
            end else if (eret_req) begin
                m_pc = epc; m_boot = 0; m_pend = 0;
            end else if (m_boot) begin
                m_boot = 0;
            end else if (stall) begin
                if (redir_valid) begin m_pend = 1; m_ptgt = redir_target; end
            end else if (m_pend) begin
                m_pc = m_ptgt; m_pend = 0;
            end else if (redir_valid) begin
                m_pc = redir_target;
            end else begin
                m_pc = m_pc + 4;
            end
        end
    end

    function automatic logic model_adel();
        if (m_boot) return 1'b0;
        return (m_pc % 4 != 0) || (m_pc < CPU_PC_LO) || (m_pc > CPU_PC_HI);
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("pc", pc, m_pc);
            check("pc_valid", {31'd0, pc_valid}, {31'd0, !m_boot});
            check("fetch_adel", {31'd0, fetch_adel}, {31'd0, model_adel()});
            check("fetch_cnt", fetch_cnt, m_cnt);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic redir(input logic [31:0] t);
        redir_valid = 1; redir_target = t;
        cyc();
        redir_valid = 0;
    endtask

    initial begin
        cyc(2);
        check("rst_pc", pc, 32'h3000);
        check("rst_valid", {31'd0, pc_valid}, 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        reset = 1;
        cyc();
        check("boot_exit_pc", pc, 32'h3000);
        check("boot_exit_valid", {31'd0, pc_valid}, 32'd1);
        cyc();
        check("seq1", pc, 32'h3004);
        cyc();
        check("seq2", pc, 32'h3008);
        cyc();
        check("cnt3", fetch_cnt, 32'd3);
        cyc();
        check("at3010", pc, 32'h3010);
        redir(32'h3100);
        check("redir", pc, 32'h3100);
        cyc();
        redir(32'h3020);
        check("redir2", pc, 32'h3020);
        // three-cycle stall, redirect in the second stall cycle
        stall = 1;
        cyc();
        check("stall1_pc", pc, 32'h3020);
        redir(32'h3200);
        check("stall2_pc", pc, 32'h3020);
        cyc();
        check("stall3_pc", pc, 32'h3020);
        check("stall_cnt", fetch_cnt, 32'd7);
        stall = 0;
        cyc();
        check("pend_taken", pc, 32'h3200);
        check("cnt_after_stall", fetch_cnt, 32'd8);
        // pending redirect then everything at once
        stall = 1;
        redir(32'h3300);
        exc_req = 1; eret_req = 1; epc = 32'h3040;
        redir(32'h3400);
        exc_req = 0; eret_req = 0; stall = 0;
        check("exc_pc", pc, 32'h4180);
        cyc();
        check("exc_no_pend", pc, 32'h4184);
        check("exc_cnt", fetch_cnt, 32'd9);
        eret_req = 1; epc = 32'h3002;
        cyc();
        eret_req = 0;
        check("eret_pc", pc, 32'h3002);
        check("eret_adel", {31'd0, fetch_adel}, 32'd1);
        redir(32'h7000);
        check("hi_adel", {31'd0, fetch_adel}, 32'd1);
        redir(32'h6ffc);
        check("edge_hi_ok", {31'd0, fetch_adel}, 32'd0);
        cyc();
        check("past_hi", pc, 32'h7000);
        redir(32'h2ffc);
        check("lo_adel", {31'd0, fetch_adel}, 32'd1);
        redir(32'hffff_fffc);
        cyc();
        check("wrap", pc, 32'h0);
        // last redirect during a stall wins
        redir(32'h3000);
        stall = 1;
        redir(32'h3500);
        redir(32'h3600);
        stall = 0;
        cyc();
        check("last_wins", pc, 32'h3600);
        // reset while holding with a redirect pending
        stall = 1;
        redir(32'h3700);
        reset = 0;
        cyc();
        check("hold_rst_pc", pc, 32'h3000);
        check("hold_rst_valid", {31'd0, pc_valid}, 32'd0);
        check("hold_rst_cnt", fetch_cnt, 32'd0);
        reset = 1; stall = 0;
        cyc(2);
        check("no_stale_pend", pc, 32'h3004);
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
# pc_seq

Fetch-stage program-counter sequencer for the pipelined MIPS core. It owns the fetch PC register and decides its next value each cycle: sequential +4, a D-stage branch/jump redirect, an exception vector, or an `eret` return. Stalls and late redirects are arbitrated through a small state machine with a pending-redirect latch. It sits between the hazard unit, the D-stage branch comparator and CP0 on one side, and the instruction memory and IF/ID register on the other.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded by reset.
- `EXC_PC`, default 32'h0000_4180: exception/interrupt vector.
- `PC_LO`, default 32'h0000_3000: lowest legal fetch address.
- `PC_HI`, default 32'h0000_6ffc: highest legal fetch address.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `stall` in 1: hazard unit freezes F and D.
- `redir_valid` in 1: single-cycle pulse from D stage; branch taken, `j`, `jal` or `jr`.
- `redir_target` in 32: redirect address, valid with `redir_valid`.
- `exc_req` in 1: CP0 exception/interrupt taken.
- `eret_req` in 1: CP0 `eret` commit.
- `epc` in 32: return address, valid with `eret_req`.
- `pc` out 32: current fetch address.
- `pc_valid` out 1: instruction at `pc` is real (0 = bubble).
- `fetch_adel` out 1: `pc` is misaligned or outside [`PC_LO`,`PC_HI`].
- `fetch_cnt` out 32: count of fetches that advanced into D.

## Operation
- States: BOOT, RUN, HOLD.
  - BOOT: entered on reset. `pc_valid` = 0. Goes unconditionally to RUN next cycle. `pc` stays `RESET_PC`.
  - RUN: `pc_valid` = 1. Goes to HOLD when `stall` = 1.
  - HOLD: `pc_valid` = 1, `pc` held. Returns to RUN when `stall` = 0.
- Next-PC priority:
  1. `reset` = 0
  2. `exc_req`
  3. `eret_req`
  4. `stall`
  5. pending redirect
  6. `redir_valid`
  7. `pc` + 4
- `exc_req`: loads `EXC_PC` from any state and forces RUN. Clears the pending latch. Ignores `stall`.
- `eret_req` (with `exc_req` = 0): loads `epc`, forces RUN, clears the pending latch.
- Pending latch:
  - `redir_valid` while `stall` = 1 captures `redir_target` into `pend_target` and sets `pend_valid`.
  - On the first cycle with `stall` = 0, `pc` <= `pend_target` and `pend_valid` clears.
  - A second `redir_valid` while pending overwrites the target (last one wins).
- `redir_valid` with `stall` = 0 and no pending redirect: `pc` <= `redir_target`. The delay-slot instruction is already in F and is not squashed here.
- Sequential: `pc` <= `pc` + 4, modulo 2^32 (wraps silently; `fetch_adel` flags it).
- `fetch_adel` is combinational from `pc`:
  - `pc[1:0]` != 0, or `pc` < `PC_LO`, or `pc` > `PC_HI`.
  - Forced to 0 in BOOT.
- `fetch_cnt`:
  - Increments when `pc_valid` = 1 and `stall` = 0.
  - Not incremented in a cycle with `exc_req` or `eret_req`.
  - Wraps at 2^32; cleared by reset.

## Timing
- All outputs are registered except `fetch_adel`.
- Reset values: `pc` = `RESET_PC`, `pc_valid` = 0, `fetch_cnt` = 0, `pend_valid` = 0, state = BOOT.
- Redirect latency is 1 cycle: a `redir_valid` at edge N gives `pc` = target after edge N.
- A redirect during a stall takes effect on the edge that ends the stall.
- Reset during HOLD or with a redirect pending discards everything. `pc` = `RESET_PC` after that edge.
- `exc_req` together with `eret_req`: exception wins.
- `exc_req` together with `stall`: exception still taken.

## Structure
- Shared package (`cpu_defs`) holds:
  - the state encoding (BOOT, RUN, HOLD) as a 2-bit enum;
  - the `RESET_PC` and `EXC_PC` defaults, so CP0 and the test bench use the same values.
- One sub-module, `pc_reg`: the 32-bit PC register with synchronous active-low reset to `RESET_PC` and a load enable.
- All next-PC selection, the FSM, the pending latch and the counter live in `pc_seq`.

## Test plan
- Release reset, no stall:
  - cycle 1: `pc` = 0x3000, `pc_valid` = 0;
  - then 0x3000, 0x3004, 0x3008 with `pc_valid` = 1;
  - `fetch_cnt` reaches 3.
- At `pc` = 0x3010, pulse `redir_valid` with target 0x3100 → next `pc` = 0x3100.
- Hold `stall` 3 cycles from `pc` = 0x3020 and pulse `redir_valid` (0x3200) in stall cycle 2:
  - `pc` stays 0x3020 throughout;
  - 0x3200 one cycle after `stall` drops;
  - `fetch_cnt` frozen during the stall.
- Same cycle `exc_req`, `eret_req` (`epc` 0x3040), `stall` and `redir_valid` → `pc` = 0x4180, `pend_valid` = 0.
- `eret_req` with `epc` = 0x3002 → `pc` = 0x3002 and `fetch_adel` = 1. Redirect to 0x7000 → `fetch_adel` = 1.
- Assert `reset` = 0 while in HOLD with a pending redirect → `pc` = 0x3000, `pc_valid` = 0, `fetch_cnt` = 0; the pending target is never taken.
